// File: rtl/enc_chk_pkg.sv
// Shared constants, types and helpers for the 8b/10b encoder-output stream checker.
package enc_chk_pkg;

   typedef enum logic {
      RD_NEG = 1'b0,
      RD_POS = 1'b1
   } rd_t;

   localparam logic [9:0] K28_1_RDN = 10'b0011111001;
   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_7_RDN = 10'b0011111000;
   localparam logic [9:0] K28_1_RDP = ~K28_1_RDN;
   localparam logic [9:0] K28_5_RDP = ~K28_5_RDN;
   localparam logic [9:0] K28_7_RDP = ~K28_7_RDN;

   function automatic logic [3:0] sym_ones(input logic [9:0] sym);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 10; i++) begin
         n = n + {3'b000, sym[i]};
      end
      return n;
   endfunction

   // Symbol disparity: ones minus zeros, -10..+10.
   function automatic logic signed [5:0] sym_disp(input logic [9:0] sym);
      return $signed({1'b0, sym_ones(sym), 1'b0}) - 6'sd10;
   endfunction

   function automatic logic is_comma(input logic [9:0] sym);
      return (sym == K28_1_RDN) || (sym == K28_5_RDN) || (sym == K28_7_RDN) ||
             (sym == K28_1_RDP) || (sym == K28_5_RDP) || (sym == K28_7_RDP);
   endfunction

endpackage

// File: rtl/enc_stream_checker_if.sv
// Encoder-output symbol bus plus the checker's status outputs.
interface enc_stream_checker_if #(
   parameter int NUM_LANES = 1,
   parameter int CNT_W     = 16
);
   logic                         TxValid;
   logic [10*NUM_LANES-1:0]      TxParallel_10;
   logic [NUM_LANES-1:0]         TxDataK;
   logic                         Clear;
   logic [NUM_LANES-1:0]         ErrRun;
   logic [NUM_LANES-1:0]         ErrDisp;
   logic [NUM_LANES-1:0]         ErrSym;
   logic [NUM_LANES-1:0]         RdPos;
   logic [CNT_W*NUM_LANES-1:0]   ErrCount;

   modport master (
      output TxValid, TxParallel_10, TxDataK, Clear,
      input  ErrRun, ErrDisp, ErrSym, RdPos, ErrCount
   );

   modport slave (
      input  TxValid, TxParallel_10, TxDataK, Clear,
      output ErrRun, ErrDisp, ErrSym, RdPos, ErrCount
   );
endinterface

// File: rtl/enc_chk_lane.sv
// One lane of the stream checker: running disparity, trailing-run tracker, sticky flags.
// Saturating error counter is present only when ENC_CHK_CNT_EN is defined.
module enc_chk_lane
   import enc_chk_pkg::*;
#(
   parameter int RUN_MAX = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   input  logic             clear_i,
   input  logic [9:0]       sym_i,
   input  logic             k_i,
   output logic             err_run_o,
   output logic             err_disp_o,
   output logic             err_sym_o,
   output logic             rd_pos_o,
   output logic [CNT_W-1:0] err_count_o
);

   localparam int LEN_W = $clog2(RUN_MAX + 2);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RUN_MAX);
   localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(RUN_MAX + 1);

   rd_t              rd_q, rd_d;
   logic             run_val_q, run_val_d;
   logic [LEN_W-1:0] run_len_q, run_len_d;
   logic             err_run_q, err_run_d;
   logic             err_disp_q, err_disp_d;
   logic             err_sym_q, err_sym_d;

   logic signed [5:0] disp;
   logic              run_hit;
   logic              run_bad;
   logic              disp_bad;
   logic              sym_bad;

   always_comb begin
      disp      = sym_disp(sym_i);
      rd_d      = rd_q;
      run_val_d = run_val_q;
      run_len_d = run_len_q;
      run_hit   = 1'b0;
      sym_bad   = 1'b0;
      disp_bad  = 1'b0;
      run_bad   = 1'b0;

      if (valid_i) begin
         sym_bad  = !((disp == -6'sd2) || (disp == 6'sd0) || (disp == 6'sd2));
         disp_bad = ((disp == 6'sd2) && (rd_q == RD_POS)) ||
                    ((disp == -6'sd2) && (rd_q == RD_NEG));

         // RD follows every symbol, including bad ones, so the checker resyncs.
         if (disp > 6'sd0) begin
            rd_d = RD_POS;
         end else if (disp < 6'sd0) begin
            rd_d = RD_NEG;
         end

         for (int i = 9; i >= 0; i--) begin
            if ((run_len_d != '0) && (sym_i[i] == run_val_d)) begin
               if (run_len_d != LEN_CAP) begin
                  run_len_d = run_len_d + LEN_ONE;
               end
            end else begin
               run_val_d = sym_i[i];
               run_len_d = LEN_ONE;
            end
            if (run_len_d > LEN_MAX) begin
               run_hit = 1'b1;
            end
         end
         run_bad = run_hit && !(k_i && is_comma(sym_i));
      end

      err_run_d  = clear_i ? 1'b0 : err_run_q;
      err_disp_d = clear_i ? 1'b0 : err_disp_q;
      err_sym_d  = clear_i ? 1'b0 : err_sym_q;
      if (run_bad)  err_run_d  = 1'b1;
      if (disp_bad) err_disp_d = 1'b1;
      if (sym_bad)  err_sym_d  = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_q       <= RD_NEG;
         run_val_q  <= 1'b0;
         run_len_q  <= '0;
         err_run_q  <= 1'b0;
         err_disp_q <= 1'b0;
         err_sym_q  <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         run_val_q  <= run_val_d;
         run_len_q  <= run_len_d;
         err_run_q  <= err_run_d;
         err_disp_q <= err_disp_d;
         err_sym_q  <= err_sym_d;
      end
   end

   assign err_run_o  = err_run_q;
   assign err_disp_o = err_disp_q;
   assign err_sym_o  = err_sym_q;
   assign rd_pos_o   = (rd_q == RD_POS);

`ifdef ENC_CHK_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             any_err;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // One increment per bad symbol regardless of how many error types it hit.
   assign any_err = run_bad || disp_bad || sym_bad;

   always_comb begin
      cnt_d = clear_i ? '0 : cnt_q;
      if (any_err && (cnt_d != '1)) begin
         cnt_d = cnt_d + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign err_count_o = cnt_q;
`else
   assign err_count_o = '0;
`endif

endmodule

// File: rtl/enc_stream_checker.sv
// Multi-lane 8b/10b encoder-output checker; one enc_chk_lane per 10-bit lane.
// Define ENC_CHK_CNT_EN to include the per-lane saturating error counters.
module enc_stream_checker
   import enc_chk_pkg::*;
#(
   parameter int NUM_LANES = 1,
   parameter int RUN_MAX   = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 BitCLK_10,
   input  logic                 Reset,
   enc_stream_checker_if.slave  bus
);

   logic [NUM_LANES-1:0]       err_run;
   logic [NUM_LANES-1:0]       err_disp;
   logic [NUM_LANES-1:0]       err_sym;
   logic [NUM_LANES-1:0]       rd_pos;
   logic [CNT_W*NUM_LANES-1:0] err_count;

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      enc_chk_lane #(
         .RUN_MAX (RUN_MAX),
         .CNT_W   (CNT_W)
      ) u_lane (
         .clk_i       (BitCLK_10),
         .rst_n_i     (Reset),
         .valid_i     (bus.TxValid),
         .clear_i     (bus.Clear),
         .sym_i       (bus.TxParallel_10[10*n +: 10]),
         .k_i         (bus.TxDataK[n]),
         .err_run_o   (err_run[n]),
         .err_disp_o  (err_disp[n]),
         .err_sym_o   (err_sym[n]),
         .rd_pos_o    (rd_pos[n]),
         .err_count_o (err_count[CNT_W*n +: CNT_W])
      );
   end

   assign bus.ErrRun   = err_run;
   assign bus.ErrDisp  = err_disp;
   assign bus.ErrSym   = err_sym;
   assign bus.RdPos    = rd_pos;
   assign bus.ErrCount = err_count;

endmodule

// File: doc/enc_stream_checker.md
# enc_stream_checker

Synthesizable, parametrised checker for the 10-bit symbol stream produced by the TX 8b/10b encoder. It tracks running disparity and run length per lane across symbol boundaries, with comma exemptions, and reports per-lane sticky error flags and saturating error counters. It sits on the encoder output bus in front of the serializer and stays in silicon as a link-health monitor readable by the register block.

## Interface
Parameters:
- NUM_LANES, 1, number of independent 10-bit lanes
- RUN_MAX, 4, longest legal run of identical bits; RUN_MAX+1 or more is an error
- CNT_W, 16, width of each per-lane error counter

Ports:
- BitCLK_10  in  1  symbol clock
- Reset  in  1  asynchronous, active-low reset
- TxValid  in  1  symbol qualifier, all lanes
- TxParallel_10  in  10*NUM_LANES  lane n at [10n+9:10n]; bit 9 is transmitted first
- TxDataK  in  NUM_LANES  control-symbol flag per lane
- Clear  in  1  synchronous clear of flags and counters
- ErrRun  out  NUM_LANES  sticky run-length error
- ErrDisp  out  NUM_LANES  sticky running-disparity error
- ErrSym  out  NUM_LANES  sticky illegal symbol disparity (|d| not 0 or 2)
- RdPos  out  NUM_LANES  current running disparity; 1 means RD+
- ErrCount  out  CNT_W*NUM_LANES  per-lane saturating error count

## Operation
Symbols are processed only on cycles where TxValid=1. When TxValid=0, all state and outputs hold.

Per lane, on each valid symbol:
- Symbol disparity: d = popcount − (10 − popcount), range −10..+10.
- ErrSym: set when d is not in {−2, 0, +2}.
- ErrDisp: set when d=+2 while RD is + (RD+), or when d=−2 while RD is − (RD−).
- RD update:
  - d=0: RD unchanged.
  - d>0: RD becomes +.
  - d<0: RD becomes −.
  - This update also applies when the symbol is in error, so the checker resyncs to the stream.
- Run length:
  - The run is computed over the carried trailing run (bit value plus length) followed by bits 9→0.
  - Any run longer than RUN_MAX sets ErrRun.
  - After the symbol, the trailing run value and length are updated, capped at RUN_MAX+1.
- Comma exemption:
  - When TxDataK=1 and the symbol equals K28.1, K28.5 or K28.7 in either polarity, the run check for that symbol is skipped.
  - The trailing-run tracker still updates.
- Error counter:
  - Increments by 1 for each valid symbol that has any of the three errors, not by 1 per error type.
  - Saturates at 2^CNT_W − 1.
- Clear=1:
  - Zeroes all flags and counters.
  - If an error is detected on the same cycle, the flag is set and the counter reads 1.
  - RD and the trailing-run tracker are not affected by Clear.
- Lanes are fully independent; there is no cross-lane ordering.

## Timing
- All outputs are registered; latency is 1 cycle from the valid symbol edge to the flag, RdPos and counter update.
- Reset values: ErrRun=0, ErrDisp=0, ErrSym=0, ErrCount=0, RdPos=0 (RD−), trailing run length=0.
- Reset asserted mid-stream clears everything immediately (asynchronous). The first symbol after release is checked against RD− with no carried run.
- A back-to-back TxValid stream at full rate is supported; there are no stall cycles.

## Configuration
- ENC_CHK_CNT_EN defined: per-lane counters are present as described above.
- ENC_CHK_CNT_EN undefined: the counter logic is removed, ErrCount is tied to 0, and the sticky flags remain unchanged.

## Structure
- Package enc_chk_pkg holds:
  - comma code constants K28_1, K28_5 and K28_7 for RD− (0011111001, 0011111010, 0011111000) and their bitwise complements for RD+;
  - typedef rd_t (RD_NEG, RD_POS);
  - the popcount/disparity function.
- Sub-module enc_chk_lane implements one lane:
  - RD register;
  - trailing-run tracker;
  - three flags;
  - optional counter.
- The top generates NUM_LANES instances of enc_chk_lane and slices the buses.

## Test plan
- Reset, then K28.5 0011111010 with TxDataK=1 followed by D21.5 1010101010 → no errors; RdPos=1 one cycle after K28.5 and stays 1.
- 0011111010 (K=1) sent twice in a row → ErrDisp=1 and ErrCount=1 after the second symbol; ErrRun=0.
- 1111100000 with K=0 → ErrRun=1, ErrSym=0, ErrDisp=0.
- 1111111000 (d=+4) → ErrSym=1, RdPos=1, ErrCount=1.
- Cross-boundary run: 1101011000 then 0011011101 with RUN_MAX=4 → ErrRun=1 after the second symbol only; no ErrDisp.
- 2^CNT_W+3 consecutive bad symbols with CNT_W=4 → ErrCount saturates at 15. Then Clear=1 together with an error symbol → ErrCount=1 and the flag stays set. Async Reset mid-stream → all outputs 0.
